// File: rtl/spi_controller.sv
// spi_controller: SPI bus master, mode 0 (sck idles low), MSB first.
// It exchanges one full-duplex DATA_WIDTH-bit word per transaction.
// Ports:
//   clk   - system clock; all logic runs on its rising edge
//   rst   - synchronous active-low reset
//   start - request a transaction (sampled only while idle)
//   din   - word to transmit, captured when start is accepted
//   dout  - last received word, updated together with done
//   busy  - high while a transaction is in progress
//   done  - one-cycle completion pulse
//   sck   - serial clock output
//   ss    - active-low slave select
//   mosi  - serial data out
//   miso  - serial data in
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  done,
  output logic                  sck,
  output logic                  ss,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

  state_t                state, state_nxt;
  logic [DIV_W-1:0]      div_cnt, div_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] tx, tx_nxt;
  logic [DATA_WIDTH-1:0] rx, rx_nxt;
  logic [DATA_WIDTH-1:0] dout_nxt;
  logic                  sck_nxt, ss_nxt, mosi_nxt, busy_nxt, done_nxt;
  logic                  div_tc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      rx      <= '0;
      dout    <= '0;
      sck     <= 1'b0;
      ss      <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      tx      <= tx_nxt;
      rx      <= rx_nxt;
      dout    <= dout_nxt;
      sck     <= sck_nxt;
      ss      <= ss_nxt;
      mosi    <= mosi_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    tx_nxt    = tx;
    rx_nxt    = rx;
    dout_nxt  = dout;
    sck_nxt   = sck;
    ss_nxt    = ss;
    mosi_nxt  = mosi;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    div_tc    = (div_cnt == DIV_LAST);

    // The divider free-runs in every active state and restarts from zero
    // on entry, so each state boundary lands on a half-period boundary.
    if (state == IDLE) begin
      div_nxt = '0;
    end else begin
      div_nxt = div_tc ? '0 : div_cnt + DIV_W'(1);
    end

    case (state)
      IDLE: begin
        if (start) begin
          tx_nxt    = din;
          ss_nxt    = 1'b0;
          mosi_nxt  = din[DATA_WIDTH-1];
          busy_nxt  = 1'b1;
          bit_nxt   = '0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (div_tc) state_nxt = TRANSFER;
      end
      TRANSFER: begin
        if (div_tc) begin
          if (!sck) begin
            sck_nxt = 1'b1;
            rx_nxt  = {rx[DATA_WIDTH-2:0], miso};
            bit_nxt = bit_cnt + BIT_W'(1);
          end else begin
            sck_nxt = 1'b0;
            // The falling edge after the last bit leaves mosi alone and
            // ends the shifting phase.
            if (bit_cnt < BIT_ALL) begin
              tx_nxt   = {tx[DATA_WIDTH-2:0], 1'b0};
              mosi_nxt = tx[DATA_WIDTH-2];
            end else begin
              state_nxt = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (div_tc) begin
          ss_nxt    = 1'b1;
          dout_nxt  = rx;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          mosi_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed self-checking bench for spi_controller.
// Two instances: CLK_DIV=4 (main tests) and CLK_DIV=1 (back-to-back test).
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  // CLK_DIV = 4 instance
  logic       start4, busy4, done4, sck4, ss4, mosi4, miso4;
  logic [7:0] din4, dout4;
  logic       loop4, pbit;

  // CLK_DIV = 1 instance
  logic       start1, busy1, done1, sck1, ss1, mosi1, miso1;
  logic [7:0] din1, dout1;

  assign miso4 = loop4 ? mosi4 : pbit;
  assign miso1 = mosi1;

  spi_controller #(.CLK_DIV(4), .DATA_WIDTH(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .din(din4), .dout(dout4),
    .busy(busy4), .done(done4), .sck(sck4), .ss(ss4), .mosi(mosi4), .miso(miso4)
  );

  spi_controller #(.CLK_DIV(1), .DATA_WIDTH(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1), .dout(dout1),
    .busy(busy1), .done(done1), .sck(sck1), .ss(ss1), .mosi(mosi1), .miso(miso1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Statistics gathered by run4
  int         rises, dones, ss_falls, bad_width, lat, fall_cyc, hi_start;
  logic [7:0] mosi_bits, dout_seen, pshift;
  logic       busy_at_done, busy_before, aborted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction on the CLK_DIV=4 instance, watched for 200 cycles.
  // disturb_at / abort_at: rising-edge number at which to re-pulse start
  // (with din=0xFF) or assert reset; 0 means never.
  task automatic run4(input logic [7:0] d, input logic lb, input logic [7:0] pdata,
                      input int disturb_at, input int abort_at);
    logic prev_sck, prev_ss, prev_busy, clear_start, abort_pending;
    rises = 0; dones = 0; ss_falls = 0; bad_width = 0; lat = -1;
    fall_cyc = 0; hi_start = 0; mosi_bits = '0; dout_seen = '0;
    busy_at_done = 1'b1; busy_before = 1'b0; aborted = 1'b0;
    abort_pending = 1'b0;
    loop4 = lb; pshift = pdata; pbit = pdata[7];
    din4 = d; start4 = 1'b1; clear_start = 1'b1;
    prev_sck = sck4; prev_ss = ss4; prev_busy = busy4;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (clear_start) begin
        start4 = 1'b0;
        clear_start = 1'b0;
      end
      if (abort_pending) begin
        check("abort_idle", 32'({ss4, sck4, busy4, done4}), 32'b1000);
        rst = 1'b1;
        abort_pending = 1'b0;
      end
      if (prev_ss && !ss4) begin
        ss_falls++;
        fall_cyc = c;
      end
      if (!prev_sck && sck4) begin
        rises++;
        mosi_bits = {mosi_bits[6:0], mosi4};
        hi_start = c;
        if (rises == disturb_at) begin
          start4 = 1'b1; din4 = 8'hFF; clear_start = 1'b1;
        end
        if (rises == abort_at) begin
          rst = 1'b0; abort_pending = 1'b1; aborted = 1'b1;
        end
      end
      if (prev_sck && !sck4) begin
        if (c - hi_start != 4) bad_width++;
        if (!lb) begin
          pshift = {pshift[6:0], 1'b0};
          pbit = pshift[7];
        end
      end
      if (done4) begin
        dones++;
        lat = c - fall_cyc;
        dout_seen = dout4;
        busy_at_done = busy4;
        busy_before = prev_busy;
      end
      prev_sck = sck4; prev_ss = ss4; prev_busy = busy4;
    end
  endtask

  initial begin
    int   nf, nd, gap;
    int   falls1 [2];
    int   lat1 [2];
    logic [7:0] dv [2];
    logic prev_ss1;

    // 1: reset held with start and miso high
    rst = 1'b0; start4 = 1'b1; start1 = 1'b1; din4 = 8'hFF; din1 = 8'hFF;
    loop4 = 1'b0; pbit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset4", 32'({sck4, ss4, mosi4, busy4, done4, dout4}), 32'({5'b01000, 8'h00}));
      check("reset1", 32'({sck1, ss1, mosi1, busy1, done1, dout1}), 32'({5'b01000, 8'h00}));
    end
    start4 = 1'b0; start1 = 1'b0; rst = 1'b1;
    @(negedge clk);

    // 2: loopback 0xA5
    run4(8'hA5, 1'b1, 8'h00, 0, 0);
    check("t2_rises", 32'(rises), 32'd8);
    check("t2_width", 32'(bad_width), 32'd0);
    check("t2_dones", 32'(dones), 32'd1);
    check("t2_latency", 32'(lat), 32'd72);
    check("t2_dout", 32'(dout_seen), 32'hA5);
    check("t2_mosi", 32'(mosi_bits), 32'hA5);
    check("t2_busy_at_done", 32'(busy_at_done), 32'd0);
    check("t2_busy_before", 32'(busy_before), 32'd1);

    // 3: peripheral model returns 0x3C
    run4(8'hC3, 1'b0, 8'h3C, 0, 0);
    check("t3_mosi", 32'(mosi_bits), 32'hC3);
    check("t3_dout", 32'(dout_seen), 32'h3C);
    check("t3_dones", 32'(dones), 32'd1);

    // 4: start re-pulsed and din changed mid-transfer
    run4(8'h5A, 1'b1, 8'h00, 3, 0);
    check("t4_rises", 32'(rises), 32'd8);
    check("t4_dones", 32'(dones), 32'd1);
    check("t4_ss_falls", 32'(ss_falls), 32'd1);
    check("t4_dout", 32'(dout_seen), 32'h5A);
    check("t4_mosi", 32'(mosi_bits), 32'h5A);

    // 5: reset mid-transfer, then a clean transfer
    run4(8'h81, 1'b1, 8'h00, 0, 3);
    check("t5_aborted", 32'(aborted), 32'd1);
    check("t5_no_done", 32'(dones), 32'd0);
    check("t5_dout_kept", 32'(dout4), 32'h00);
    run4(8'hFF, 1'b1, 8'h00, 0, 0);
    check("t5_dout", 32'(dout_seen), 32'hFF);
    check("t5_dones", 32'(dones), 32'd1);

    // 6: back-to-back at CLK_DIV=1 with start held high
    nf = 0; nd = 0; gap = 0;
    falls1[0] = 0; falls1[1] = 0; lat1[0] = -1; lat1[1] = -1;
    dv[0] = '0; dv[1] = '0;
    prev_ss1 = ss1;
    start1 = 1'b1; din1 = 8'h12;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (prev_ss1 && !ss1) begin
        if (nf < 2) falls1[nf] = c;
        nf++;
      end
      if (done1) begin
        if (nd < 2) begin
          lat1[nd] = c - falls1[nd];
          dv[nd] = dout1;
        end
        nd++;
        if (nd == 1) din1 = 8'h34;
        else start1 = 1'b0;
      end
      if (ss1 && nd == 1 && nf == 1) gap++;
      prev_ss1 = ss1;
    end
    start1 = 1'b0;
    check("t6_dones", 32'(nd), 32'd2);
    check("t6_lat0", 32'(lat1[0]), 32'd18);
    check("t6_lat1", 32'(lat1[1]), 32'd18);
    check("t6_dout0", 32'(dv[0]), 32'h12);
    check("t6_dout1", 32'(dv[1]), 32'h34);
    check("t6_ss_gap", 32'(gap >= 1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
